date_counter: RTL and testbench
===============================

Name: date_counter

Overview:
Running calendar register that sits directly downstream of the date-set mode block. While the date-set mode is active it follows the edited date. On leaving that mode it loads the edited date, clamped to a legal calendar date. Outside set mode it advances the date by one day on each DAY_TICK from the time-of-day counter, handling month lengths, Gregorian leap years and BCD year carry; its outputs feed the display mux.

Parameters:
MODE_DATE_SET, 4'b0011, MODE encoding of date-set mode.

Ports:
CLK  input  1  system clock, rising edge.
RESET  input  1  asynchronous, active-low reset.
MODE  input  4  current mode from the mode controller.
DAY_TICK  input  1  one-cycle pulse at 23:59:59 -> 00:00:00 rollover.
SET_YEAR1000, SET_YEAR100, SET_YEAR10, SET_YEAR1  input  4 each  BCD year digits from the date-set block.
SET_MONTH  input  7  binary month from the date-set block; may hold 0 or values above 12.
SET_DAY  input  7  binary day from the date-set block; may hold 0 or values up to 39.
YEAR1000, YEAR100, YEAR10, YEAR1  output  4 each  current BCD year digits.
MONTH  output  7  current month, binary, 1..12.
DAY  output  7  current day, binary, 1..month length.
LEAP  output  1  current year is a leap year (combinational from the year registers).
YEAR_CARRY  output  1  one-cycle pulse when the date rolls from 12/31 to 01/01.

Behaviour:
- Reset (RESET=0, asynchronous):
  - YEAR digits = 2,0,2,0; MONTH=1; DAY=1; YEAR_CARRY=0; internal prev-mode flag=0.
  - LEAP therefore reads 1.
- Leap rule:
  - Year divisible by 400 -> leap.
  - Else divisible by 100 -> not leap.
  - Else divisible by 4 -> leap.
  - Evaluated on the BCD digits: tens parity with the units digit, thousands parity with the hundreds digit.
- Month length: 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; month 2 is 29 if leap, else 28.
- In set mode (MODE==MODE_DATE_SET):
  - Registers are not updated; outputs hold the last running date.
  - DAY_TICK is ignored, not queued.
  - Prev-mode flag is set to 1.
- Exit load: first rising edge with MODE!=MODE_DATE_SET while the prev-mode flag is 1. On that edge load:
  - Each SET year digit >9 -> 9.
  - SET_MONTH 0 -> 1; SET_MONTH >12 -> 12.
  - SET_DAY 0 -> 1; SET_DAY > length(clamped month, year being loaded) -> that length.
  - Outputs are valid 1 cycle after the exit edge. Prev-mode flag clears.
- DAY_TICK on the same edge as an exit load: the load wins and the tick is dropped.
- Day advance (DAY_TICK=1, not in set mode, no load on this edge):
  - DAY < length -> DAY+1.
  - Else DAY=1 and:
    - MONTH<12 -> MONTH+1.
    - MONTH==12 -> MONTH=1, year +1 in BCD with ripple carry; 9999 wraps to 0000.
    - YEAR_CARRY=1 for exactly that cycle.
- YEAR_CARRY returns to 0 on every edge without a year rollover.
- Back-to-back DAY_TICK on consecutive cycles each advance one day.
- Reset mid-operation overrides everything immediately; no load is pending after reset release, even if MODE==MODE_DATE_SET at release.

Test Plan:
1. Assert RESET=0 then release, MODE=0 -> 2020/01/01, LEAP=1, YEAR_CARRY=0. Pulse DAY_TICK -> 2020/01/02.
2. Enter MODE=0011, pulse DAY_TICK -> date unchanged. Apply SET 2021/02/39, then MODE=0000 -> next cycle 2021/02/28, LEAP=0. SET_MONTH=0, SET_DAY=0 in the same flow -> 2021/01/01.
3. Load 2024/02/28, two DAY_TICKs -> 2024/02/29, then 2024/03/01. Load 2100/02/28, one tick -> 2100/03/01. Load 2000/02/28, one tick -> 2000/02/29.
4. Load 1999/12/31, one tick -> 2000/01/01 with YEAR_CARRY high for exactly one cycle, LEAP=1. Load 9999/12/31, one tick -> 0000/01/01, LEAP=1.
5. Hold SET 2022/04/30; drive DAY_TICK=1 on the same edge MODE leaves 0011 -> 2022/04/30, tick dropped. Next tick -> 2022/05/01.
6. Assert RESET low mid-sequence at 2023/06/15 -> 2020/01/01 asynchronously, before the next CLK edge.

Source files
------------

// File: rtl/date_counter.sv
// rtl/date_counter.sv - running BCD-year calendar register with set-mode load and clamping
module date_counter #(
  parameter logic [3:0] MODE_DATE_SET = 4'b0011
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] MODE,
  input  logic       DAY_TICK,
  input  logic [3:0] SET_YEAR1000,
  input  logic [3:0] SET_YEAR100,
  input  logic [3:0] SET_YEAR10,
  input  logic [3:0] SET_YEAR1,
  input  logic [6:0] SET_MONTH,
  input  logic [6:0] SET_DAY,
  output logic [3:0] YEAR1000,
  output logic [3:0] YEAR100,
  output logic [3:0] YEAR10,
  output logic [3:0] YEAR1,
  output logic [6:0] MONTH,
  output logic [6:0] DAY,
  output logic       LEAP,
  output logic       YEAR_CARRY
);

  // A two-digit BCD value is a multiple of 4 when an even tens digit pairs with
  // units 0/4/8, or an odd tens digit pairs with units 2/6.
  function automatic logic div4_bcd(input logic [3:0] tens, input logic [3:0] units);
    if (tens[0]) return (units == 4'd2) || (units == 4'd6);
    return (units == 4'd0) || (units == 4'd4) || (units == 4'd8);
  endfunction

  function automatic logic leap_bcd(input logic [3:0] d3, input logic [3:0] d2,
                                    input logic [3:0] d1, input logic [3:0] d0);
    if ((d1 == 4'd0) && (d0 == 4'd0)) return div4_bcd(d3, d2);
    return div4_bcd(d1, d0);
  endfunction

  function automatic logic [6:0] month_len(input logic [6:0] m, input logic leap);
    case (m)
      7'd4, 7'd6, 7'd9, 7'd11: return 7'd30;
      7'd2:                    return leap ? 7'd29 : 7'd28;
      default:                 return 7'd31;
    endcase
  endfunction

  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  logic       prev_set;
  logic       in_set, do_load, do_tick;
  logic [3:0] ld_y3, ld_y2, ld_y1, ld_y0;
  logic       ld_leap;
  logic [6:0] ld_month, ld_len, ld_day;
  logic [6:0] cur_len;
  logic [3:0] inc_y3, inc_y2, inc_y1, inc_y0;
  logic [3:0] nxt_y3, nxt_y2, nxt_y1, nxt_y0;
  logic [6:0] nxt_month, nxt_day;
  logic       nxt_carry, nxt_prev;

  assign in_set  = (MODE == MODE_DATE_SET);
  assign do_load = !in_set && prev_set;
  // A tick coinciding with the exit load is deliberately lost.
  assign do_tick = DAY_TICK && !in_set && !do_load;

  assign LEAP    = leap_bcd(YEAR1000, YEAR100, YEAR10, YEAR1);
  assign cur_len = month_len(MONTH, LEAP);

  assign ld_y3    = clamp_digit(SET_YEAR1000);
  assign ld_y2    = clamp_digit(SET_YEAR100);
  assign ld_y1    = clamp_digit(SET_YEAR10);
  assign ld_y0    = clamp_digit(SET_YEAR1);
  assign ld_leap  = leap_bcd(ld_y3, ld_y2, ld_y1, ld_y0);
  assign ld_month = (SET_MONTH == 7'd0) ? 7'd1 : ((SET_MONTH > 7'd12) ? 7'd12 : SET_MONTH);
  assign ld_len   = month_len(ld_month, ld_leap);
  assign ld_day   = (SET_DAY == 7'd0) ? 7'd1 : ((SET_DAY > ld_len) ? ld_len : SET_DAY);

  always_comb begin
    inc_y3 = YEAR1000;
    inc_y2 = YEAR100;
    inc_y1 = YEAR10;
    inc_y0 = YEAR1 + 4'd1;
    if (YEAR1 == 4'd9) begin
      inc_y0 = 4'd0;
      inc_y1 = YEAR10 + 4'd1;
      if (YEAR10 == 4'd9) begin
        inc_y1 = 4'd0;
        inc_y2 = YEAR100 + 4'd1;
        if (YEAR100 == 4'd9) begin
          inc_y2 = 4'd0;
          inc_y3 = (YEAR1000 == 4'd9) ? 4'd0 : YEAR1000 + 4'd1;
        end
      end
    end
  end

  always_comb begin
    nxt_y3    = YEAR1000;
    nxt_y2    = YEAR100;
    nxt_y1    = YEAR10;
    nxt_y0    = YEAR1;
    nxt_month = MONTH;
    nxt_day   = DAY;
    nxt_carry = 1'b0;
    nxt_prev  = in_set;
    if (do_load) begin
      nxt_y3    = ld_y3;
      nxt_y2    = ld_y2;
      nxt_y1    = ld_y1;
      nxt_y0    = ld_y0;
      nxt_month = ld_month;
      nxt_day   = ld_day;
    end else if (do_tick) begin
      if (DAY < cur_len) begin
        nxt_day = DAY + 7'd1;
      end else begin
        nxt_day = 7'd1;
        if (MONTH < 7'd12) begin
          nxt_month = MONTH + 7'd1;
        end else begin
          nxt_month = 7'd1;
          nxt_y3    = inc_y3;
          nxt_y2    = inc_y2;
          nxt_y1    = inc_y1;
          nxt_y0    = inc_y0;
          nxt_carry = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      YEAR1000   <= 4'd2;
      YEAR100    <= 4'd0;
      YEAR10     <= 4'd2;
      YEAR1      <= 4'd0;
      MONTH      <= 7'd1;
      DAY        <= 7'd1;
      YEAR_CARRY <= 1'b0;
      prev_set   <= 1'b0;
    end else begin
      YEAR1000   <= nxt_y3;
      YEAR100    <= nxt_y2;
      YEAR10     <= nxt_y1;
      YEAR1      <= nxt_y0;
      MONTH      <= nxt_month;
      DAY        <= nxt_day;
      YEAR_CARRY <= nxt_carry;
      prev_set   <= nxt_prev;
    end
  end

endmodule

// File: tb/tb_date_counter.sv
// tb/tb_date_counter.sv - table, directed and randomized checks of date_counter against a calendar model
module tb_date_counter;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic [3:0] MODE = 4'd0;
  logic       DAY_TICK = 1'b0;
  logic [3:0] SET_YEAR1000 = 4'd0, SET_YEAR100 = 4'd0, SET_YEAR10 = 4'd0, SET_YEAR1 = 4'd0;
  logic [6:0] SET_MONTH = 7'd0, SET_DAY = 7'd0;
  logic [3:0] YEAR1000, YEAR100, YEAR10, YEAR1;
  logic [6:0] MONTH, DAY;
  logic       LEAP, YEAR_CARRY;

  int checks = 0;
  int failures = 0;

  date_counter dut (
    .CLK(CLK), .RESET(RESET), .MODE(MODE), .DAY_TICK(DAY_TICK),
    .SET_YEAR1000(SET_YEAR1000), .SET_YEAR100(SET_YEAR100),
    .SET_YEAR10(SET_YEAR10), .SET_YEAR1(SET_YEAR1),
    .SET_MONTH(SET_MONTH), .SET_DAY(SET_DAY),
    .YEAR1000(YEAR1000), .YEAR100(YEAR100), .YEAR10(YEAR10), .YEAR1(YEAR1),
    .MONTH(MONTH), .DAY(DAY), .LEAP(LEAP), .YEAR_CARRY(YEAR_CARRY)
  );

  always #5 CLK = ~CLK;

  // Calendar reference model on plain integers.
  int m_year, m_month, m_day;

  function automatic bit is_leap(input int y);
    return (y % 400 == 0) || ((y % 100 != 0) && (y % 4 == 0));
  endfunction

  function automatic int days_in(input int m, input int y);
    int len[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m == 2 && is_leap(y)) return 29;
    return len[m-1];
  endfunction

  task automatic model_load(input int y3, input int y2, input int y1, input int y0,
                            input int m, input int d);
    m_year  = (y3 > 9 ? 9 : y3) * 1000 + (y2 > 9 ? 9 : y2) * 100
            + (y1 > 9 ? 9 : y1) * 10 + (y0 > 9 ? 9 : y0);
    m_month = (m < 1) ? 1 : ((m > 12) ? 12 : m);
    m_day   = (d < 1) ? 1 : ((d > days_in(m_month, m_year)) ? days_in(m_month, m_year) : d);
  endtask

  task automatic model_tick(output bit carry);
    carry = 1'b0;
    m_day++;
    if (m_day > days_in(m_month, m_year)) begin
      m_day = 1;
      m_month++;
      if (m_month > 12) begin
        m_month = 1;
        m_year  = (m_year + 1) % 10000;
        carry   = 1'b1;
      end
    end
  endtask

  task automatic check_state(input string name, input int ey, input int em, input int ed,
                             input bit el, input bit ec);
    logic [29:0] got, want;
    got  = {YEAR1000, YEAR100, YEAR10, YEAR1, MONTH, DAY};
    want = {4'(ey / 1000), 4'((ey / 100) % 10), 4'((ey / 10) % 10), 4'(ey % 10), 7'(em), 7'(ed)};
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s date: got %0d%0d%0d%0d/%0d/%0d want %0d/%0d/%0d", name,
               YEAR1000, YEAR100, YEAR10, YEAR1, MONTH, DAY, ey, em, ed);
    end
    checks++;
    if (LEAP !== el) begin
      failures++;
      $display("FAIL %s leap: got %b want %b", name, LEAP, el);
    end
    checks++;
    if (YEAR_CARRY !== ec) begin
      failures++;
      $display("FAIL %s year_carry: got %b want %b", name, YEAR_CARRY, ec);
    end
  endtask

  task automatic step(input bit tick);
    DAY_TICK = tick;
    @(posedge CLK);
    #1;
    DAY_TICK = 1'b0;
  endtask

  task automatic set_inputs(input int y3, input int y2, input int y1, input int y0,
                            input int m, input int d);
    SET_YEAR1000 = y3[3:0];
    SET_YEAR100  = y2[3:0];
    SET_YEAR10   = y1[3:0];
    SET_YEAR1    = y0[3:0];
    SET_MONTH    = m[6:0];
    SET_DAY      = d[6:0];
  endtask

  task automatic load(input int y3, input int y2, input int y1, input int y0,
                      input int m, input int d);
    set_inputs(y3, y2, y1, y0, m, d);
    MODE = 4'b0011;
    step(1'b0);
    MODE = 4'b0000;
    step(1'b0);
  endtask

  typedef struct {
    int sy3, sy2, sy1, sy0, sm, sd;
    int ey, em, ed;
    bit el;
  } load_vec_t;

  load_vec_t lv[10];
  bit        c;
  int        r, ry3, ry2, ry1, ry0, rm, rd;

  initial begin
    lv[0] = '{2, 0, 2, 1,   2,  39, 2021,  2, 28, 1'b0};
    lv[1] = '{2, 0, 2, 1,   0,   0, 2021,  1,  1, 1'b0};
    lv[2] = '{2, 0, 2, 4,   2,  31, 2024,  2, 29, 1'b1};
    lv[3] = '{15, 12, 10, 11, 13, 35, 9999, 12, 31, 1'b0};
    lv[4] = '{2, 1, 0, 0,   2,  30, 2100,  2, 28, 1'b0};
    lv[5] = '{2, 0, 0, 0,   2,  30, 2000,  2, 29, 1'b1};
    lv[6] = '{2, 0, 2, 3,   4,  31, 2023,  4, 30, 1'b0};
    lv[7] = '{2, 0, 2, 3, 127,   0, 2023, 12,  1, 1'b0};
    lv[8] = '{1, 9, 0, 0,   2,  29, 1900,  2, 28, 1'b0};
    lv[9] = '{0, 0, 0, 0,   9,  31,    0,  9, 30, 1'b1};

    // Reset state and first tick
    RESET = 1'b0;
    step(1'b0);
    step(1'b0);
    check_state("reset", 2020, 1, 1, 1'b1, 1'b0);
    RESET = 1'b1;
    step(1'b0);
    check_state("after_release", 2020, 1, 1, 1'b1, 1'b0);
    step(1'b1);
    check_state("first_tick", 2020, 1, 2, 1'b1, 1'b0);

    // Set mode freezes the date and ignores ticks
    set_inputs(2, 0, 2, 1, 2, 39);
    MODE = 4'b0011;
    step(1'b1);
    step(1'b1);
    check_state("set_mode_hold", 2020, 1, 2, 1'b1, 1'b0);
    MODE = 4'b0000;
    step(1'b0);
    check_state("exit_clamp_day", 2021, 2, 28, 1'b0, 1'b0);
    step(1'b0);
    check_state("no_reload", 2021, 2, 28, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      load(lv[i].sy3, lv[i].sy2, lv[i].sy1, lv[i].sy0, lv[i].sm, lv[i].sd);
      check_state($sformatf("load_vec%0d", i), lv[i].ey, lv[i].em, lv[i].ed, lv[i].el, 1'b0);
    end

    // Leap-year February ends
    load(2, 0, 2, 4, 2, 28);
    step(1'b1);
    check_state("2024_feb29", 2024, 2, 29, 1'b1, 1'b0);
    step(1'b1);
    check_state("2024_mar01", 2024, 3, 1, 1'b1, 1'b0);
    load(2, 1, 0, 0, 2, 28);
    step(1'b1);
    check_state("2100_mar01", 2100, 3, 1, 1'b0, 1'b0);
    load(2, 0, 0, 0, 2, 28);
    step(1'b1);
    check_state("2000_feb29", 2000, 2, 29, 1'b1, 1'b0);

    // Year rollovers and single-cycle carry pulse
    load(1, 9, 9, 9, 12, 31);
    step(1'b1);
    check_state("rollover_2000", 2000, 1, 1, 1'b1, 1'b1);
    step(1'b0);
    check_state("carry_drops", 2000, 1, 1, 1'b1, 1'b0);
    load(9, 9, 9, 9, 12, 31);
    step(1'b1);
    check_state("wrap_0000", 0, 1, 1, 1'b1, 1'b1);

    // Back-to-back ticks across a month end
    load(2, 0, 2, 3, 1, 30);
    step(1'b1);
    step(1'b1);
    step(1'b1);
    check_state("back_to_back", 2023, 2, 2, 1'b0, 1'b0);

    // Tick on the exit edge is dropped
    set_inputs(2, 0, 2, 2, 4, 30);
    MODE = 4'b0011;
    step(1'b0);
    MODE = 4'b0000;
    step(1'b1);
    check_state("exit_tick_dropped", 2022, 4, 30, 1'b0, 1'b0);
    step(1'b1);
    check_state("tick_after_exit", 2022, 5, 1, 1'b0, 1'b0);

    // Asynchronous reset while a load is pending
    load(2, 0, 2, 3, 6, 15);
    set_inputs(2, 0, 1, 1, 11, 11);
    MODE = 4'b0011;
    step(1'b0);
    check_state("pre_reset", 2023, 6, 15, 1'b0, 1'b0);
    #2;
    RESET = 1'b0;
    #1;
    check_state("async_reset", 2020, 1, 1, 1'b1, 1'b0);
    MODE = 4'b0000;
    step(1'b0);
    RESET = 1'b1;
    step(1'b0);
    check_state("no_load_after_reset", 2020, 1, 1, 1'b1, 1'b0);

    // Randomized loads and ticks against the model
    load(2, 0, 2, 0, 1, 1);
    model_load(2, 0, 2, 0, 1, 1);
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8) begin
        ry3 = (r < 2) ? 9 : $urandom_range(0, 15);
        ry2 = (r < 2) ? 9 : $urandom_range(0, 15);
        ry1 = $urandom_range(0, 15);
        ry0 = $urandom_range(0, 15);
        rm  = (r < 5) ? 12 : $urandom_range(0, 20);
        rd  = (r < 5) ? $urandom_range(28, 39) : $urandom_range(0, 39);
        load(ry3, ry2, ry1, ry0, rm, rd);
        model_load(ry3, ry2, ry1, ry0, rm, rd);
        check_state("rand_load", m_year, m_month, m_day, is_leap(m_year), 1'b0);
      end else if (r < 85) begin
        step(1'b1);
        model_tick(c);
        check_state("rand_tick", m_year, m_month, m_day, is_leap(m_year), c);
      end else begin
        step(1'b0);
        check_state("rand_idle", m_year, m_month, m_day, is_leap(m_year), 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
